xtx_accumulator: RTL and testbench

Streaming front-end of the regression datapath. It accepts a burst of signed (x, y) samples and accumulates the sufficient statistics n, Σx, Σx², Σy and Σxy. At the end of the burst it presents them, with a one-cycle `finished` pulse, to the XᵀX inverse stage directly downstream. It forms both XᵀX = [[n, Σx], [Σx, Σx²]] and XᵀY = [Σy, Σxy] for the downstream solve.

---
 rtl/xtx_accumulator_if.sv | 34 +++
 rtl/xtx_accumulator.sv | 164 ++++++++++++++++
 tb/tb_xtx_accumulator.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/xtx_accumulator_if.sv
// Sample-stream and result bus between the burst source, the accumulator and
// the downstream XtX inverse stage.
interface xtx_accumulator_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 10,
  parameter int ACC_W  = 2*DATA_W + CNT_W
);
  logic                     start;
  logic                     sample_valid;
  logic                     sample_ready;
  logic signed [DATA_W-1:0] x_in;
  logic signed [DATA_W-1:0] y_in;
  logic                     last;
  logic                     busy;
  logic                     finished;
  logic                     overflow;
  logic        [CNT_W-1:0]  n_out;
  logic signed [ACC_W-1:0]  sum_x;
  logic signed [ACC_W-1:0]  sum_xx;
  logic signed [ACC_W-1:0]  sum_y;
  logic signed [ACC_W-1:0]  sum_xy;

  modport master (
    output start, sample_valid, x_in, y_in, last,
    input  sample_ready, busy, finished, overflow,
    input  n_out, sum_x, sum_xx, sum_y, sum_xy
  );

  modport slave (
    input  start, sample_valid, x_in, y_in, last,
    output sample_ready, busy, finished, overflow,
    output n_out, sum_x, sum_xx, sum_y, sum_xy
  );
endinterface

// File: rtl/xtx_accumulator.sv
// Burst accumulator for n, sum x, sum x^2, sum y, sum xy feeding the XtX / XtY
// solve; two-stage multiply/accumulate pipeline behind a valid/ready handshake.
module xtx_accumulator #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 10,
  parameter int ACC_W  = 2*DATA_W + CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  xtx_accumulator_if.slave io_bus
);
  localparam int PW = 2*DATA_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Count of samples already taken when the one that closes the burst arrives.
  localparam logic [CNT_W-1:0] PRE_MAX = CNT_W'((1 << CNT_W) - 2);

  function automatic logic signed [ACC_W-1:0] sext_d(input logic signed [DATA_W-1:0] v);
    return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  function automatic logic signed [ACC_W-1:0] sext_p(input logic signed [PW-1:0] v);
    return {{(ACC_W-PW){v[PW-1]}}, v};
  endfunction

  logic [1:0]              r_state;
  logic [1:0]              w_state_next;
  logic                    r_ready;
  logic                    r_busy;
  logic                    r_finished;

  logic                    r_s1_valid;
  logic signed [ACC_W-1:0] r_s1_x;
  logic signed [ACC_W-1:0] r_s1_y;
  logic signed [PW-1:0]    r_s1_xx;
  logic signed [PW-1:0]    r_s1_xy;

  logic signed [ACC_W-1:0] r_acc_x;
  logic signed [ACC_W-1:0] r_acc_xx;
  logic signed [ACC_W-1:0] r_acc_y;
  logic signed [ACC_W-1:0] r_acc_xy;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_ovf;

  logic [CNT_W-1:0]        r_n_out;
  logic signed [ACC_W-1:0] r_sum_x;
  logic signed [ACC_W-1:0] r_sum_xx;
  logic signed [ACC_W-1:0] r_sum_y;
  logic signed [ACC_W-1:0] r_sum_xy;
  logic                    r_overflow;

  logic signed [PW-1:0]    w_xw;
  logic signed [PW-1:0]    w_yw;
  logic [CNT_W-1:0]        w_taken;
  logic                    w_accept;
  logic                    w_start;
  logic                    w_at_max;
  logic                    w_end_burst;
  logic                    w_load;

  assign w_xw = {{DATA_W{io_bus.x_in[DATA_W-1]}}, io_bus.x_in};
  assign w_yw = {{DATA_W{io_bus.y_in[DATA_W-1]}}, io_bus.y_in};

  // Samples taken so far = accumulated ones plus the one still in stage 1.
  assign w_taken     = r_cnt + CNT_W'(r_s1_valid);
  assign w_accept    = io_bus.sample_valid && r_ready;
  assign w_start     = (r_state == S_IDLE) && io_bus.start;
  assign w_at_max    = (w_taken == PRE_MAX);
  assign w_end_burst = w_accept && (io_bus.last || w_at_max);
  assign w_load      = (r_state == S_FLUSH) && !r_s1_valid;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (io_bus.start) w_state_next = S_ACCUM;
      S_ACCUM: if (w_end_burst) w_state_next = S_FLUSH;
      // Stay until stage 1 has drained into the accumulators.
      S_FLUSH: if (!r_s1_valid) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_finished <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
      r_s1_xx    <= '0;
      r_s1_xy    <= '0;
      r_acc_x    <= '0;
      r_acc_xx   <= '0;
      r_acc_y    <= '0;
      r_acc_xy   <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_n_out    <= '0;
      r_sum_x    <= '0;
      r_sum_xx   <= '0;
      r_sum_y    <= '0;
      r_sum_xy   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_ready    <= (w_state_next == S_ACCUM);
      r_busy     <= (w_state_next != S_IDLE);
      r_finished <= (w_state_next == S_DONE);

      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_x  <= sext_d(io_bus.x_in);
        r_s1_y  <= sext_d(io_bus.y_in);
        r_s1_xx <= w_xw * w_xw;
        r_s1_xy <= w_xw * w_yw;
      end

      if (w_start) begin
        r_acc_x  <= '0;
        r_acc_xx <= '0;
        r_acc_y  <= '0;
        r_acc_xy <= '0;
        r_cnt    <= '0;
        r_ovf    <= 1'b0;
      end else begin
        if (r_s1_valid) begin
          r_acc_x  <= r_acc_x + r_s1_x;
          r_acc_xx <= r_acc_xx + sext_p(r_s1_xx);
          r_acc_y  <= r_acc_y + r_s1_y;
          r_acc_xy <= r_acc_xy + sext_p(r_s1_xy);
          r_cnt    <= r_cnt + CNT_W'(1);
        end
        if (w_accept && w_at_max && !io_bus.last) r_ovf <= 1'b1;
      end

      // Results are only replaced here, so the consumer may read them late.
      if (w_load) begin
        r_n_out    <= r_cnt;
        r_sum_x    <= r_acc_x;
        r_sum_xx   <= r_acc_xx;
        r_sum_y    <= r_acc_y;
        r_sum_xy   <= r_acc_xy;
        r_overflow <= r_ovf;
      end
    end
  end

  assign io_bus.sample_ready = r_ready;
  assign io_bus.busy         = r_busy;
  assign io_bus.finished     = r_finished;
  assign io_bus.overflow     = r_overflow;
  assign io_bus.n_out        = r_n_out;
  assign io_bus.sum_x        = r_sum_x;
  assign io_bus.sum_xx       = r_sum_xx;
  assign io_bus.sum_y        = r_sum_y;
  assign io_bus.sum_xy       = r_sum_xy;
endmodule

// File: tb/tb_xtx_accumulator.sv
// Directed and randomized bursts against a plain-arithmetic model of the
// sufficient statistics, with handshake and completion timing checks.
`timescale 1ns/1ps
module tb_xtx_accumulator;
  localparam int DW   = 32;
  localparam int CW   = 3;
  localparam int AW   = 2*DW + CW;
  localparam int MAXS = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  int q_x[$];
  int q_y[$];
  bit q_l[$];

  int                   e_n;
  bit                   e_ovf;
  logic signed [AW-1:0] e_sx, e_sxx, e_sy, e_sxy;

  xtx_accumulator_if #(.DATA_W(DW), .CNT_W(CW), .ACC_W(AW)) bus ();

  xtx_accumulator #(.DATA_W(DW), .CNT_W(CW), .ACC_W(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io_bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int x, input int y, input bit l);
    q_x.push_back(x);
    q_y.push_back(y);
    q_l.push_back(l);
  endtask

  // Samples are taken in order until one carries last or the count hits the maximum.
  task automatic model();
    logic signed [AW-1:0] mx, my;
    e_n = 0; e_ovf = 0;
    e_sx = '0; e_sxx = '0; e_sy = '0; e_sxy = '0;
    for (int j = 0; j < q_x.size(); j++) begin
      mx = q_x[j];
      my = q_y[j];
      e_n++;
      e_sx  = e_sx + mx;
      e_sxx = e_sxx + mx * mx;
      e_sy  = e_sy + my;
      e_sxy = e_sxy + mx * my;
      if (q_l[j]) break;
      if (e_n == MAXS) begin
        e_ovf = 1;
        break;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".n"},   bus.n_out, e_n);
    check({tag, ".sx"},  bus.sum_x, e_sx);
    check({tag, ".sxx"}, bus.sum_xx, e_sxx);
    check({tag, ".sy"},  bus.sum_y, e_sy);
    check({tag, ".sxy"}, bus.sum_xy, e_sxy);
    check({tag, ".ovf"}, bus.overflow, e_ovf);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".ready"},    bus.sample_ready, 0);
    check({tag, ".busy"},     bus.busy, 0);
    check({tag, ".finished"}, bus.finished, 0);
    check({tag, ".ovf"},      bus.overflow, 0);
    check({tag, ".n"},        bus.n_out, 0);
    check({tag, ".sx"},       bus.sum_x, 0);
    check({tag, ".sxx"},      bus.sum_xx, 0);
    check({tag, ".sy"},       bus.sum_y, 0);
    check({tag, ".sxy"},      bus.sum_xy, 0);
  endtask

  // Inputs change on falling edges; a sample is taken at the next rising edge
  // when valid is driven while sample_ready reads high.
  task automatic run_burst(input string tag, input int gap_max, input bit poke);
    int i, acc, k_edge, gap, budget, w;
    bit ended;
    model();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    check({tag, ".ready_up"}, bus.sample_ready, 1);
    i = 0; acc = 0; k_edge = 0; ended = 0; budget = 0; gap = 0;
    while (!ended && budget < 200) begin
      budget++;
      if (bus.sample_ready !== 1'b1 || i >= q_x.size()) begin
        ended = 1;
      end else begin
        if (poke) bus.start = ($urandom_range(2, 0) == 0);
        if (gap > 0) begin
          bus.sample_valid = 1'b0;
          bus.x_in = $urandom;
          bus.y_in = $urandom;
          bus.last = 1'($urandom_range(1, 0));
          gap--;
        end else begin
          bus.sample_valid = 1'b1;
          bus.x_in = q_x[i];
          bus.y_in = q_y[i];
          bus.last = q_l[i];
          i++; acc++;
          k_edge = cyc + 1;
          gap = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
        end
        @(negedge clk);
      end
    end
    bus.sample_valid = 1'b0;
    bus.last = 1'b0;
    bus.start = 1'b0;
    check({tag, ".accepted"}, acc, e_n);
    check({tag, ".busy_flush"}, bus.busy, 1);
    w = 0;
    while (bus.finished !== 1'b1 && w < 8) begin
      @(negedge clk);
      w++;
    end
    check({tag, ".finish_lat"}, cyc - k_edge, 2);
    check_outputs(tag);
    if (poke) bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, ".fin_low"},  bus.finished, 0);
    check({tag, ".busy_low"}, bus.busy, 0);
    check({tag, ".rdy_low"},  bus.sample_ready, 0);
    $display("burst %s: n=%0d ovf=%0d sx=%0d sxx=%0d sy=%0d sxy=%0d", tag, e_n, e_ovf, e_sx, e_sxx, e_sy, e_sxy);
  endtask

  task automatic load_s1();
    q_x.delete(); q_y.delete(); q_l.delete();
    push(1, 3, 0); push(2, 5, 0); push(3, 7, 1);
  endtask

  initial begin
    int len;
    bus.start = 1'b0; bus.sample_valid = 1'b0; bus.last = 1'b0;
    bus.x_in = '0; bus.y_in = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);
    check_zero("post_reset");

    load_s1();
    run_burst("s1", 0, 0);
    check("s1.sxy_const", bus.sum_xy, 34);
    check("s1.sxx_const", bus.sum_xx, 14);

    q_x.delete(); q_y.delete(); q_l.delete();
    push(-2, 4, 0); push(3, -1, 1);
    run_burst("s2_nogap", 0, 0);
    run_burst("s2_gap", 3, 0);
    check("s2.sxy_const", $signed(bus.sum_xy), -11);

    q_x.delete(); q_y.delete(); q_l.delete();
    for (int j = 0; j < 8; j++) push(5, 5, 0);
    run_burst("s3", 0, 0);
    check("s3.ovf_const", bus.overflow, 1);
    check("s3.n_const", bus.n_out, 7);

    q_x.delete(); q_y.delete(); q_l.delete();
    push(int'(32'h8000_0000), int'(32'h8000_0000), 1);
    run_burst("s4", 0, 0);
    check("s4.sxx_const", bus.sum_xx, 128'h1 << 62);
    check("s4.sxy_const", bus.sum_xy, 128'h1 << 62);

    load_s1();
    run_burst("s5", 1, 1);
    for (int j = 0; j < 3; j++) begin
      bus.sample_valid = 1'b1;
      bus.x_in = $urandom; bus.y_in = $urandom; bus.last = 1'b1;
      @(negedge clk);
      check("s5.idle_ready", bus.sample_ready, 0);
      check("s5.idle_busy", bus.busy, 0);
    end
    bus.sample_valid = 1'b0; bus.last = 1'b0;
    @(negedge clk);
    check_outputs("s5.idle_hold");

    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    bus.sample_valid = 1'b1; bus.x_in = 9; bus.y_in = 9; bus.last = 1'b0;
    @(negedge clk); @(negedge clk);
    bus.sample_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check_zero("s6.in_reset");
    @(negedge clk); @(negedge clk);
    check_zero("s6.hold_reset");
    reset_n = 1'b1;
    @(negedge clk);
    check_zero("s6.after_reset");
    load_s1();
    run_burst("s6", 0, 0);

    for (int b = 0; b < 8; b++) begin
      q_x.delete(); q_y.delete(); q_l.delete();
      len = $urandom_range(9, 1);
      for (int j = 0; j < len; j++) begin
        push(int'($urandom), int'($urandom), ($urandom_range(3, 0) == 0) || (j == len - 1 && len <= MAXS));
      end
      run_burst($sformatf("rnd%0d", b), 2, 1'($urandom_range(1, 0)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
